// File: rtl/key_schedule_pkg.sv
// rtl/key_schedule_pkg.sv - shared AES constants, S-box table and key-schedule FSM state
package key_schedule_pkg;

  localparam logic [3:0] NUM_ROUNDS = 4'd10;

  // Byte k of RCON_TABLE is Rcon for round k+1.
  localparam logic [79:0] RCON_TABLE = 80'h36_1b_80_40_20_10_08_04_02_01;

  // Entry 0 sits in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } ks_state_t;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [3:0] idx;
    idx = rnd - 4'd1;
    if (rnd >= 4'd1 && rnd <= NUM_ROUNDS) return RCON_TABLE[{idx, 3'b000} +: 8];
    return 8'h00;
  endfunction

endpackage

// File: rtl/aes_subword.sv
// rtl/aes_subword.sv - four parallel AES S-box lookups on one 32-bit word
module aes_subword
  import key_schedule_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] sub_word
);

  always_comb begin
    sub_word = '0;
    for (int i = 0; i < 4; i++) sub_word[8*i +: 8] = sbox(word[8*i +: 8]);
  end

endmodule

// File: rtl/key_schedule_expand.sv
// rtl/key_schedule_expand.sv - AES-128 next-round-key word arithmetic
module key_schedule_expand
  import key_schedule_pkg::*;
(
  input  logic [3:0]   rnd,
  input  logic [127:0] key,
  input  logic [31:0]  sub_word,
  output logic [127:0] next_key
);

  logic [31:0] rot_word;
  logic [31:0] w0, w1, w2, w3;

  // Byte 0 is the least significant byte, so RotWord is a right rotation here.
  assign rot_word = {sub_word[7:0], sub_word[31:8]};
  assign w0 = rot_word ^ key[31:0] ^ {24'h000000, rcon(rnd)};
  assign w1 = w0 ^ key[63:32];
  assign w2 = w1 ^ key[95:64];
  assign w3 = w2 ^ key[127:96];
  assign next_key = {w3, w2, w1, w0};

endmodule

// File: rtl/key_schedule.sv
// rtl/key_schedule.sv - AES-128 round-key streamer with optional round-key buffer
module key_schedule
  import key_schedule_pkg::*;
#(
  parameter int STORE_KEYS = 1
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         start_in,
  input  logic [127:0] key_in,
  output logic         busy_out,
  output logic         rk_valid_out,
  input  logic         rk_ready_in,
  output logic [3:0]   rk_round_out,
  output logic [127:0] rk_out,
  output logic         done_out,
  input  logic [3:0]   rd_addr_in,
  output logic [127:0] rd_data_out
);

  ks_state_t    state_q, state_d;
  logic [127:0] cur_key, key_d;
  logic [3:0]   round_q, round_d;
  logic         done_q, done_d;
  logic [31:0]  sub_word;
  logic [127:0] next_key;
  logic         wr_en;
  logic [3:0]   wr_addr;
  logic [127:0] wr_data;

  aes_subword u_subword (
    .word     (cur_key[127:96]),
    .sub_word (sub_word)
  );

  key_schedule_expand u_expand (
    .rnd      (round_q + 4'd1),
    .key      (cur_key),
    .sub_word (sub_word),
    .next_key (next_key)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      cur_key <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_key <= key_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = cur_key;
    round_d = round_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    wr_addr = round_q + 4'd1;
    wr_data = next_key;
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          state_d = ST_EMIT;
          key_d   = key_in;
          round_d = 4'd0;
          wr_en   = 1'b1;
          wr_addr = 4'd0;
          wr_data = key_in;
        end
      end
      ST_EMIT: begin
        if (rk_ready_in) begin
          if (round_q == NUM_ROUNDS) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            key_d   = next_key;
            round_d = round_q + 4'd1;
            wr_en   = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_out     = (state_q != ST_IDLE);
  assign rk_valid_out = (state_q == ST_EMIT);
  assign rk_round_out = round_q;
  assign rk_out       = cur_key;
  assign done_out     = done_q;

  if (STORE_KEYS != 0) begin : g_store
    logic [127:0] key_buf [0:10];
    logic [127:0] rd_q;

    // The array is deliberately left out of reset; stale entries stay readable.
    always_ff @(posedge clk_in) begin
      if (wr_en) key_buf[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk_in) begin
      if (rst_in) rd_q <= '0;
      else if (rd_addr_in <= NUM_ROUNDS) rd_q <= key_buf[rd_addr_in];
      else rd_q <= '0;
    end

    assign rd_data_out = rd_q;
  end else begin : g_no_store
    assign rd_data_out = '0;
  end

endmodule

// File: tb/tb_key_schedule.sv
// tb/tb_key_schedule.sv - self-checking bench for key_schedule against a FIPS-197 byte model
module tb_key_schedule;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         start_in;
  logic [127:0] key_in;
  logic         busy_out;
  logic         rk_valid_out;
  logic         rk_ready_in;
  logic [3:0]   rk_round_out;
  logic [127:0] rk_out;
  logic         done_out;
  logic [3:0]   rd_addr_in;
  logic [127:0] rd_data_out;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]   sb [0:255];
  logic [127:0] exp_rk [0:10];
  logic [127:0] obs_rk [0:10];

  localparam logic [127:0] FIPS_KEY = 128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b;
  localparam logic [127:0] FIPS_R1  = 128'h05766c2a_3939a323_b12c5488_17fefaa0;
  localparam logic [127:0] FIPS_R10 = 128'ha60c63b6_c80c3fe1_8925eec9_a8f914d0;

  key_schedule dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .start_in     (start_in),
    .key_in       (key_in),
    .busy_out     (busy_out),
    .rk_valid_out (rk_valid_out),
    .rk_ready_in  (rk_ready_in),
    .rk_round_out (rk_round_out),
    .rk_out       (rk_out),
    .done_out     (done_out),
    .rd_addr_in   (rd_addr_in),
    .rd_data_out  (rd_data_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its algebraic definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [7:0] w [0:175];
    logic [7:0] t [0:3];
    logic [7:0] tmp;
    logic [7:0] rc;
    for (int i = 0; i < 16; i++) w[i] = key[8*i +: 8];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int n = 0; n < 4; n++) t[n] = w[4*(i-1) + n];
      if (i % 4 == 0) begin
        tmp  = t[0];
        t[0] = sb[t[1]] ^ rc;
        t[1] = sb[t[2]];
        t[2] = sb[t[3]];
        t[3] = sb[tmp];
        rc   = xtime(rc);
      end
      for (int n = 0; n < 4; n++) w[4*i + n] = w[4*(i-4) + n] ^ t[n];
    end
    for (int r = 0; r < 11; r++)
      for (int n = 0; n < 16; n++) exp_rk[r][8*n +: 8] = w[16*r + n];
  endtask

  // mode: 0 ready high, 1 stall 5 cycles at round 4, 2 start pulse at round 3,
  //       3 reset at round 6, 4 random ready
  task automatic run_expansion(input logic [127:0] key, input int mode);
    int rnd;
    int cyc;
    int stall;
    logic rdy;
    model_expand(key);
    start_in = 1'b1;
    key_in   = key;
    @(negedge clk_in);
    start_in = 1'b0;
    key_in   = {$urandom, $urandom, $urandom, $urandom};
    rnd = 0;
    cyc = 0;
    stall = 0;
    while (rnd <= 10 && cyc < 400) begin
      check($sformatf("valid r%0d", rnd), 128'(rk_valid_out), 128'(1));
      check($sformatf("busy r%0d", rnd), 128'(busy_out), 128'(1));
      check($sformatf("done early r%0d", rnd), 128'(done_out), 128'(0));
      check($sformatf("round r%0d", rnd), 128'(rk_round_out), 128'(rnd));
      check($sformatf("rk_out r%0d", rnd), rk_out, exp_rk[rnd]);
      obs_rk[rnd] = rk_out;
      if (mode == 3 && rnd == 6) begin
        rst_in = 1'b1;
        rk_ready_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        check("rst busy", 128'(busy_out), 128'(0));
        check("rst valid", 128'(rk_valid_out), 128'(0));
        check("rst done", 128'(done_out), 128'(0));
        check("rst round", 128'(rk_round_out), 128'(0));
        check("rst rk_out", rk_out, 128'(0));
        check("rst rd_data", rd_data_out, 128'(0));
        for (int i = 0; i < 14; i++) begin
          @(negedge clk_in);
          check("no done after abort", 128'(done_out), 128'(0));
        end
        rk_ready_in = 1'b0;
        return;
      end
      case (mode)
        1: begin
          rdy = !(rnd == 4 && stall < 5);
          if (!rdy) stall++;
        end
        4: rdy = 1'($urandom_range(0, 1));
        default: rdy = 1'b1;
      endcase
      start_in = (mode == 2 && rnd == 3);
      key_in   = ~key;
      rk_ready_in = rdy;
      @(negedge clk_in);
      cyc++;
      if (rdy) rnd++;
    end
    rk_ready_in = 1'b0;
    start_in = 1'b0;
    check("all rounds seen", 128'(rnd), 128'(11));
    if (mode == 0 || mode == 2) check("latency cycles", 128'(cyc), 128'(11));
    if (mode == 1) check("stall cycles", 128'(cyc), 128'(16));
    check("done pulse", 128'(done_out), 128'(1));
    check("idle busy", 128'(busy_out), 128'(0));
    check("idle valid", 128'(rk_valid_out), 128'(0));
    @(negedge clk_in);
    check("done one cycle", 128'(done_out), 128'(0));
  endtask

  task automatic read_check(input logic [3:0] addr, input logic [127:0] expv);
    rd_addr_in = addr;
    @(negedge clk_in);
    check($sformatf("rd_data a%0d", addr), rd_data_out, expv);
  endtask

  initial begin
    rst_in = 1'b1;
    start_in = 1'b0;
    key_in = '0;
    rk_ready_in = 1'b0;
    rd_addr_in = 4'd0;
    build_sbox();
    @(negedge clk_in);
    start_in = 1'b1;
    key_in = FIPS_KEY;
    rk_ready_in = 1'b1;
    @(negedge clk_in);
    check("reset busy", 128'(busy_out), 128'(0));
    check("reset valid", 128'(rk_valid_out), 128'(0));
    check("reset done", 128'(done_out), 128'(0));
    check("reset round", 128'(rk_round_out), 128'(0));
    check("reset rk_out", rk_out, 128'(0));
    check("reset rd_data", rd_data_out, 128'(0));
    rst_in = 1'b0;
    start_in = 1'b0;
    rk_ready_in = 1'b0;
    @(negedge clk_in);
    check("idle hold", 128'(busy_out), 128'(0));

    run_expansion(FIPS_KEY, 0);
    check("fips round1", obs_rk[1], FIPS_R1);
    check("fips round10", obs_rk[10], FIPS_R10);
    read_check(4'd10, FIPS_R10);
    read_check(4'd12, 128'(0));
    read_check(4'd0, FIPS_KEY);

    run_expansion({$urandom, $urandom, $urandom, $urandom}, 1);
    run_expansion(FIPS_KEY, 2);
    check("busy-start round1", obs_rk[1], FIPS_R1);
    check("busy-start round10", obs_rk[10], FIPS_R10);
    run_expansion({$urandom, $urandom, $urandom, $urandom}, 3);
    run_expansion({$urandom, $urandom, $urandom, $urandom}, 0);
    for (int k = 0; k < 4; k++) run_expansion({$urandom, $urandom, $urandom, $urandom}, 4);

    for (int a = 0; a < 16; a++) read_check(4'(a), (a <= 10) ? exp_rk[a] : 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/key_schedule.md
KEY_SCHEDULE -- requirements
Module: key_schedule

Interface
REQ-001 SHALL have parameter STORE_KEYS, default 1; 1 = build the 11-entry round-key buffer and read port, 0 = rd_data_out ties to 0.
REQ-002 SHALL have port clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_in, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start_in, input, 1 bit: request expansion of key_in; sampled only in IDLE.
REQ-005 SHALL have port key_in, input, 128 bits: AES-128 cipher key; byte i at bits [8i+7:8i], word j at [32j+31:32j].
REQ-006 SHALL have port busy_out, output, 1 bit: high in every state except IDLE.
REQ-007 SHALL have port rk_valid_out, output, 1 bit: round-key stream valid.
REQ-008 SHALL have port rk_ready_in, input, 1 bit: round-key stream ready from the cipher datapath.
REQ-009 SHALL have port rk_round_out, output, 4 bits: round index 0..10 of rk_out.
REQ-010 SHALL have port rk_out, output, 128 bits: round key, same byte/word ordering as key_in.
REQ-011 SHALL have port done_out, output, 1 bit: one-cycle pulse after round key 10 is accepted.
REQ-012 SHALL have port rd_addr_in, input, 4 bits: buffer read address.
REQ-013 SHALL have port rd_data_out, output, 128 bits: registered buffer read data.

Function
REQ-014 SHALL implement FSM states IDLE and EMIT; a handshake SHALL occur in any cycle where rk_valid_out and rk_ready_in are both high.
REQ-015 In IDLE with start_in=1, SHALL latch key_in into cur_key, set round=0, write buf[0]=key_in, and enter EMIT.
REQ-016 In IDLE, start_in=0 SHALL hold state; in EMIT, start_in SHALL be ignored.
REQ-017 In EMIT, SHALL drive rk_valid_out=1, rk_out=cur_key and rk_round_out=round, all registered.
REQ-018 In EMIT, outputs SHALL stay stable while rk_ready_in=0; the stall length is unbounded.
REQ-019 On a handshake with round<10, SHALL set cur_key to the next key, increment round, write buf[round+1], and remain in EMIT.
REQ-020 The next key SHALL be computed as follows: SubWord = per-byte AES S-box of cur_key[127:96]; RotWord = {sub[7:0], sub[31:8]}; w0' = RotWord ^ w0 ^ Rcon(round+1) on byte 0; wj' = wj'-1 ^ wj for j=1..3.
REQ-021 Rcon SHALL take these values for rounds 1..10: 01,02,04,08,10,20,40,80,1b,36.
REQ-022 On a handshake with round=10, SHALL return to IDLE and pulse done_out high for exactly the next cycle.
REQ-023 Latency: with rk_ready_in held high and start accepted at cycle T, round r SHALL be valid at cycle T+1+r, and done_out SHALL be high at T+12.
REQ-024 SHALL accept a new start_in no earlier than the cycle in which done_out is high, since the block is then in IDLE.
REQ-025 rd_data_out SHALL equal buf[rd_addr_in] one cycle after the address is sampled; addresses 11..15 SHALL read 0.
REQ-026 Entries not yet written in the current expansion SHALL read their previous content; the buffer carries no valid flags.

Reset
REQ-027 On rst_in=1, SHALL enter IDLE and hold busy_out=0, rk_valid_out=0, done_out=0, rk_round_out=0, rk_out=0 and rd_data_out=0.
REQ-028 rst_in SHALL have priority over start_in and handshakes; a reset mid-expansion SHALL abort it with no done_out pulse.
REQ-029 Reset SHALL NOT clear the buffer array.

Structure
REQ-030 The shared AES package SHALL hold the S-box table constant, the Rcon constant, the NUM_ROUNDS=10 constant and the FSM state typedef.
REQ-031 SHALL instantiate the existing key-expansion sub-module for REQ-020 word arithmetic, passing round+1 and cur_key.
REQ-032 SHALL contain one new sub-module, aes_subword, which performs the 4-byte S-box lookup on cur_key[127:96].

Verification
REQ-033 FIPS-197 vector: key_in=128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b with ready held high -> round 1 = 128'h05766c2a_3939a323_b12c5488_17fefaa0, round 10 = 128'ha60c63b6_c80c3fe1_8925eec9_a8f914d0, done_out at T+12.
REQ-034 Backpressure: drop rk_ready_in for 5 cycles at round 4 -> rk_out and rk_round_out held stable, and the sequence resumes unchanged.
REQ-035 Start while busy: pulse start_in with a different key at round 3 -> ignored, and the stream is identical to REQ-033.
REQ-036 Reset mid-run: assert rst_in at round 6 -> IDLE, all outputs 0 the next cycle, no done_out; a restart then produces the full correct sequence.
REQ-037 Read port: after REQ-033 completes, rd_addr_in=10 -> REQ-033 round 10 value one cycle later; rd_addr_in=12 -> 0.
